// File: rtl/health_round_controller.sv
// health_round_controller: fighter health, hit acceptance
// and best-of-N round/match sequencing for the HUD.
module health_round_controller #(
  parameter int HEALTH_W      = 9,
  parameter int MAX_HEALTH    = 200,
  parameter int DMG_HEAVY     = 40,
  parameter int DMG_MED       = 10,
  parameter int DMG_LIGHT     = 4,
  parameter int IFRAME_CYCLES = 8,
  parameter int ROUND_SECS    = 99,
  parameter int PAUSE_TICKS   = 3,
  parameter int WIN_ROUNDS    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start,
  input  logic                hit_on_1,
  input  logic                hit_on_2,
  input  logic [2:0]          attack_state_1,
  input  logic [2:0]          attack_state_2,
  output logic [HEALTH_W-1:0] health_1,
  output logic [HEALTH_W-1:0] health_2,
  output logic [1:0]          rounds_1,
  output logic [1:0]          rounds_2,
  output logic [6:0]          round_time,
  output logic [2:0]          state,
  output logic                dmg_pulse_1,
  output logic                dmg_pulse_2
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FIGHT      = 3'd1,
    S_ROUND_P1   = 3'd2,
    S_ROUND_P2   = 3'd3,
    S_ROUND_DRAW = 3'd4,
    S_MATCH_P1   = 3'd5,
    S_MATCH_P2   = 3'd6
  } state_t;

  localparam logic [HEALTH_W-1:0] H_MAX =
    HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] D_HVY =
    HEALTH_W'(DMG_HEAVY);
  localparam logic [HEALTH_W-1:0] D_MED =
    HEALTH_W'(DMG_MED);
  localparam logic [HEALTH_W-1:0] D_LGT =
    HEALTH_W'(DMG_LIGHT);
  localparam logic [7:0] IF_LOAD =
    8'(IFRAME_CYCLES);
  localparam logic [6:0] T_LOAD =
    7'(ROUND_SECS);
  localparam logic [7:0] P_LAST =
    8'(PAUSE_TICKS - 1);
  localparam logic [1:0] R_WIN =
    2'(WIN_ROUNDS);

  state_t st;

  logic [7:0] iframe_1;
  logic [7:0] iframe_2;
  logic [7:0] pause_cnt;
  logic       q_1;
  logic       q_2;
  logic       q_1_d;
  logic       q_2_d;
  logic       alive;
  logic       acc_1;
  logic       acc_2;
  logic [HEALTH_W-1:0] dmg_1;
  logic [HEALTH_W-1:0] dmg_2;

  function automatic logic [HEALTH_W-1:0] dmg_of(
    input logic [2:0] code
  );
    logic [HEALTH_W-1:0] d;
    d = '0;
    case (code)
      3'd1:    d = D_LGT;
      3'd2:    d = D_MED;
      3'd3:    d = D_HVY;
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [HEALTH_W-1:0] sat_sub(
    input logic [HEALTH_W-1:0] h,
    input logic [HEALTH_W-1:0] d
  );
    return (h > d) ? h - d : '0;
  endfunction

  // fighter 1 is hit by fighter 2's attack, and vice versa
  assign q_1 = hit_on_1 &&
               (attack_state_2 != 3'd0) &&
               (attack_state_2 < 3'd4);
  assign q_2 = hit_on_2 &&
               (attack_state_1 != 3'd0) &&
               (attack_state_1 < 3'd4);

  assign dmg_1 = dmg_of(attack_state_2);
  assign dmg_2 = dmg_of(attack_state_1);

  assign alive = (health_1 != '0) &&
                 (health_2 != '0);

  assign acc_1 = (st == S_FIGHT) && q_1 &&
                 !q_1_d && (iframe_1 == 8'd0) &&
                 alive;
  assign acc_2 = (st == S_FIGHT) && q_2 &&
                 !q_2_d && (iframe_2 == 8'd0) &&
                 alive;

  assign state = st;

  // rising-edge history so a held attack lands once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_1_d <= 1'b0;
      q_2_d <= 1'b0;
    end else begin
      q_1_d <= q_1;
      q_2_d <= q_2;
    end
  end

  // post-hit invulnerability windows, live only in FIGHT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iframe_1 <= 8'd0;
      iframe_2 <= 8'd0;
    end else if (st != S_FIGHT) begin
      iframe_1 <= 8'd0;
      iframe_2 <= 8'd0;
    end else begin
      if (acc_1)
        iframe_1 <= IF_LOAD;
      else if (iframe_1 != 8'd0)
        iframe_1 <= iframe_1 - 8'd1;
      if (acc_2)
        iframe_2 <= IF_LOAD;
      else if (iframe_2 != 8'd0)
        iframe_2 <= iframe_2 - 8'd1;
    end
  end

  // match FSM with health, timer and round bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= S_IDLE;
      health_1    <= H_MAX;
      health_2    <= H_MAX;
      rounds_1    <= 2'd0;
      rounds_2    <= 2'd0;
      round_time  <= T_LOAD;
      pause_cnt   <= 8'd0;
      dmg_pulse_1 <= 1'b0;
      dmg_pulse_2 <= 1'b0;
    end else begin
      dmg_pulse_1 <= acc_1;
      dmg_pulse_2 <= acc_2;
      unique case (st)
        S_IDLE, S_MATCH_P1, S_MATCH_P2: begin
          if (start) begin
            st         <= S_FIGHT;
            health_1   <= H_MAX;
            health_2   <= H_MAX;
            round_time <= T_LOAD;
            rounds_1   <= 2'd0;
            rounds_2   <= 2'd0;
          end
        end
        S_FIGHT: begin
          if (acc_1)
            health_1 <= sat_sub(health_1, dmg_1);
          if (acc_2)
            health_2 <= sat_sub(health_2, dmg_2);
          if (tick && round_time != 7'd0)
            round_time <= round_time - 7'd1;
          pause_cnt <= 8'd0;
          if (health_1 == '0 && health_2 == '0) begin
            st <= S_ROUND_DRAW;
          end else if (health_2 == '0) begin
            st       <= S_ROUND_P1;
            rounds_1 <= rounds_1 + 2'd1;
          end else if (health_1 == '0) begin
            st       <= S_ROUND_P2;
            rounds_2 <= rounds_2 + 2'd1;
          end else if (round_time == 7'd0) begin
            if (health_1 > health_2) begin
              st       <= S_ROUND_P1;
              rounds_1 <= rounds_1 + 2'd1;
            end else if (health_2 > health_1) begin
              st       <= S_ROUND_P2;
              rounds_2 <= rounds_2 + 2'd1;
            end else begin
              st <= S_ROUND_DRAW;
            end
          end
        end
        S_ROUND_P1, S_ROUND_P2, S_ROUND_DRAW: begin
          if (tick) begin
            if (pause_cnt == P_LAST) begin
              pause_cnt <= 8'd0;
              if (st == S_ROUND_P1 &&
                  rounds_1 == R_WIN) begin
                st <= S_MATCH_P1;
              end else if (st == S_ROUND_P2 &&
                           rounds_2 == R_WIN) begin
                st <= S_MATCH_P2;
              end else begin
                st         <= S_FIGHT;
                health_1   <= H_MAX;
                health_2   <= H_MAX;
                round_time <= T_LOAD;
              end
            end else begin
              pause_cnt <= pause_cnt + 8'd1;
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_health_round_controller.sv
// tb_health_round_controller: directed stimulus with a
// cycle-level behavioural match model and per-cycle compare.
module tb_health_round_controller;

  localparam int MAXH = 200;
  localparam int DH   = 40;
  localparam int DM   = 10;
  localparam int DL   = 4;
  localparam int IFC  = 8;
  localparam int RS   = 99;
  localparam int PT   = 3;
  localparam int WR   = 2;

  logic       clk = 0;
  logic       reset = 0;
  logic       tick = 0;
  logic       start = 0;
  logic       hit_on_1 = 0;
  logic       hit_on_2 = 0;
  logic [2:0] attack_state_1 = 0;
  logic [2:0] attack_state_2 = 0;
  logic [8:0] health_1;
  logic [8:0] health_2;
  logic [1:0] rounds_1;
  logic [1:0] rounds_2;
  logic [6:0] round_time;
  logic [2:0] state;
  logic       dmg_pulse_1;
  logic       dmg_pulse_2;

  int n_cmp = 0;
  int n_bad = 0;
  int np2 = 0;
  bit m_ok = 0;

  int c2[7] = '{3, 3, 2, 2, 1, 1, 1};

  always #5 clk = ~clk;

  health_round_controller #(
    .HEALTH_W(9), .MAX_HEALTH(MAXH),
    .DMG_HEAVY(DH), .DMG_MED(DM), .DMG_LIGHT(DL),
    .IFRAME_CYCLES(IFC), .ROUND_SECS(RS),
    .PAUSE_TICKS(PT), .WIN_ROUNDS(WR)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .start(start),
    .hit_on_1(hit_on_1), .hit_on_2(hit_on_2),
    .attack_state_1(attack_state_1),
    .attack_state_2(attack_state_2),
    .health_1(health_1), .health_2(health_2),
    .rounds_1(rounds_1), .rounds_2(rounds_2),
    .round_time(round_time), .state(state),
    .dmg_pulse_1(dmg_pulse_1),
    .dmg_pulse_2(dmg_pulse_2)
  );

  // model: index 0 = fighter 1, index 1 = fighter 2
  // invulnerability kept as an "accept again from
  // cycle" deadline rather than a down-counter
  int m_st = 0;
  int m_t = RS;
  int m_pz = 0;
  int m_cyc = 0;
  int m_h[2] = '{MAXH, MAXH};
  int m_r[2] = '{0, 0};
  int m_inv[2] = '{0, 0};
  bit m_pq[2] = '{0, 0};
  bit m_pulse[2] = '{0, 0};

  function automatic int dmg(input logic [2:0] c);
    return (c == 3) ? DH : (c == 2) ? DM :
           (c == 1) ? DL : 0;
  endfunction

  task automatic m_reset();
    m_st = 0; m_t = RS; m_pz = 0; m_cyc = 0;
    m_h = '{MAXH, MAXH};
    m_r = '{0, 0};
    m_inv = '{0, 0};
    m_pq = '{0, 0};
    m_pulse = '{0, 0};
  endtask

  task automatic m_load();
    m_h = '{MAXH, MAXH};
    m_t = RS;
  endtask

  task automatic m_step();
    bit q[2];
    int d[2];
    int h[2];
    bit alive;
    int w;
    q[0] = hit_on_1 && (attack_state_2 inside {[1:3]});
    q[1] = hit_on_2 && (attack_state_1 inside {[1:3]});
    d[0] = dmg(attack_state_2);
    d[1] = dmg(attack_state_1);
    h = m_h;
    alive = (h[0] > 0) && (h[1] > 0);
    m_pulse = '{0, 0};
    if (m_st == 1) begin
      for (int f = 0; f < 2; f++) begin
        if (q[f] && !m_pq[f] && alive &&
            m_cyc >= m_inv[f]) begin
          m_h[f] = (h[f] > d[f]) ? h[f] - d[f] : 0;
          m_pulse[f] = 1;
          m_inv[f] = m_cyc + IFC + 1;
        end
      end
      w = -1;
      if (h[0] == 0 && h[1] == 0) w = 2;
      else if (h[1] == 0) w = 0;
      else if (h[0] == 0) w = 1;
      else if (m_t == 0)
        w = (h[0] > h[1]) ? 0 : (h[1] > h[0]) ? 1 : 2;
      if (tick && m_t > 0) m_t = m_t - 1;
      if (w == 2) begin
        m_st = 4; m_pz = 0;
      end else if (w >= 0) begin
        m_r[w] = m_r[w] + 1;
        m_st = 2 + w; m_pz = 0;
      end
    end else begin
      m_inv = '{0, 0};
      if (m_st == 0 || m_st >= 5) begin
        if (start) begin
          m_st = 1; m_load(); m_r = '{0, 0};
        end
      end else if (tick) begin
        m_pz = m_pz + 1;
        if (m_pz == PT) begin
          m_pz = 0;
          if (m_st != 4 && m_r[m_st - 2] == WR)
            m_st = 5 + (m_st - 2);
          else begin
            m_st = 1; m_load();
          end
        end
      end
    end
    m_pq = q;
    m_cyc = m_cyc + 1;
  endtask

  // model advances on the same edges as the DUT
  always @(posedge clk or negedge reset) begin
    if (!reset) m_reset();
    else m_step();
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (dmg_pulse_2 === 1'b1) np2++;
    if (m_ok) begin
      chk("state", state, m_st);
      chk("health_1", health_1, m_h[0]);
      chk("health_2", health_2, m_h[1]);
      chk("rounds_1", rounds_1, m_r[0]);
      chk("rounds_2", rounds_2, m_r[1]);
      chk("round_time", round_time, m_t);
      chk("dmg_pulse_1", dmg_pulse_1, m_pulse[0]);
      chk("dmg_pulse_2", dmg_pulse_2, m_pulse[1]);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hit(input int f,
                     input logic [2:0] code);
    if (f == 1) begin
      hit_on_1 = 1; attack_state_2 = code;
    end else begin
      hit_on_2 = 1; attack_state_1 = code;
    end
    step(1);
    hit_on_1 = 0; hit_on_2 = 0;
    attack_state_1 = 0; attack_state_2 = 0;
  endtask

  task automatic tk(input int n);
    repeat (n) begin
      tick = 1; step(1);
      tick = 0; step(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    chk("rst_state", state, 0);
    chk("rst_h1", health_1, 200);
    chk("rst_h2", health_2, 200);
    chk("rst_rt", round_time, 99);
    m_ok = 1;
    reset = 1; step(1);

    start = 1; step(1); start = 0;
    chk("start_state", state, 1);
    chk("start_h2", health_2, 200);
    chk("start_rt", round_time, 99);

    np2 = 0;
    hit_on_2 = 1; attack_state_1 = 3;
    step(20);
    hit_on_2 = 0; attack_state_1 = 0;
    chk("held_h2", health_2, 160);
    chk("held_pulses", np2, 1);
    step(10);

    hit(2, 1);
    chk("light1_h2", health_2, 156);
    step(2);
    hit(2, 1);
    chk("light_iframe_h2", health_2, 156);
    step(9);
    hit(2, 1);
    chk("light3_h2", health_2, 152);
    step(10);

    start = 1; step(2); start = 0;
    chk("start_ignored", state, 1);

    for (int i = 0; i < 4; i++) begin
      hit(1, 3); step(9);
    end
    for (int i = 0; i < 7; i++) begin
      hit(2, 3'(c2[i])); step(9);
    end
    chk("pre_draw_h1", health_1, 40);
    chk("pre_draw_h2", health_2, 40);

    hit_on_1 = 1; hit_on_2 = 1;
    attack_state_1 = 3; attack_state_2 = 3;
    step(1);
    hit_on_1 = 0; hit_on_2 = 0;
    attack_state_1 = 0; attack_state_2 = 0;
    chk("draw_h1", health_1, 0);
    chk("draw_h2", health_2, 0);
    step(1);
    chk("draw_state", state, 4);
    chk("draw_r1", rounds_1, 0);
    chk("draw_r2", rounds_2, 0);
    tk(3);
    chk("after_draw_state", state, 1);
    chk("after_draw_h1", health_1, 200);
    chk("after_draw_rt", round_time, 99);

    for (int i = 0; i < 2; i++) begin
      hit(1, 3); step(9);
    end
    for (int i = 0; i < 3; i++) begin
      hit(2, 3); step(9);
    end
    chk("to_h1", health_1, 120);
    chk("to_h2", health_2, 80);
    tick = 1; step(99); tick = 0;
    chk("to_rt", round_time, 0);
    chk("to_wait_state", state, 1);
    step(1);
    chk("to_state", state, 2);
    chk("to_r1", rounds_1, 1);
    tk(3);
    chk("r2_state", state, 1);
    chk("r2_r1_kept", rounds_1, 1);

    for (int i = 0; i < 5; i++) begin
      hit(2, 3); step(9);
    end
    chk("ko_h2", health_2, 0);
    chk("ko_state", state, 2);
    chk("ko_r1", rounds_1, 2);
    tk(3);
    chk("match_state", state, 5);
    start = 1; step(1); start = 0;
    chk("rematch_state", state, 1);
    chk("rematch_r1", rounds_1, 0);
    chk("rematch_r2", rounds_2, 0);

    hit(1, 3);
    chk("pre_rst_pulse", dmg_pulse_1, 1);
    reset = 0; #1;
    chk("arst_state", state, 0);
    chk("arst_h1", health_1, 200);
    chk("arst_pulse", dmg_pulse_1, 0);
    chk("arst_rt", round_time, 99);
    step(2);
    reset = 1; step(2);
    chk("post_rst_state", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
